// File: rtl/regfile_rename.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : regfile_rename                                                |
// | Brief    : Architectural register file with busy bit and ROB tag per reg |
// |            and combinational read ports that bypass same-cycle commits.   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module regfile_rename #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8,
    parameter int IDX_W  = $clog2(NREGS),
    parameter int TAG_W  = 3,
    parameter int NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     dispatch_en,
    input  logic [IDX_W-1:0]         dispatch_dest,
    input  logic [TAG_W-1:0]         dispatch_tag,
    input  logic                     commit_en,
    input  logic [IDX_W-1:0]         commit_dest,
    input  logic [TAG_W-1:0]         commit_tag,
    input  logic [DATA_W-1:0]        commit_data,
    input  logic [NUM_RD*IDX_W-1:0]  rd_idx,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    output logic [NUM_RD*TAG_W-1:0]  rd_tag
);

    logic [DATA_W-1:0] r_data [NREGS];
    logic [TAG_W-1:0]  r_tag  [NREGS];
    logic [NREGS-1:0]  r_busy;

    // Commit clears busy first; flush or a younger dispatch then overrides it.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_data[i] <= '0;
                r_tag[i]  <= '0;
            end
            r_busy <= '0;
        end else begin
            if (commit_en) begin
                r_data[commit_dest] <= commit_data;
                if (r_busy[commit_dest] && (r_tag[commit_dest] == commit_tag)) begin
                    r_busy[commit_dest] <= 1'b0;
                end
            end
            if (flush) begin
                r_busy <= '0;
            end else if (dispatch_en) begin
                r_busy[dispatch_dest] <= 1'b1;
                r_tag[dispatch_dest]  <= dispatch_tag;
            end
        end
    end

    // Reads see the commit of this cycle but not the dispatch of this cycle.
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [IDX_W-1:0] w_idx;
        logic             w_cmatch;
        logic             w_tmatch;

        assign w_idx    = rd_idx[p*IDX_W +: IDX_W];
        assign w_cmatch = commit_en && (commit_dest == w_idx);
        assign w_tmatch = r_busy[w_idx] && (r_tag[w_idx] == commit_tag);

        assign rd_data[p*DATA_W +: DATA_W] = w_cmatch ? commit_data : r_data[w_idx];
        assign rd_busy[p]                  = r_busy[w_idx] & ~(w_cmatch & w_tmatch);
        assign rd_tag[p*TAG_W +: TAG_W]    = r_tag[w_idx];
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_rename.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_regfile_rename                                             |
// | Brief    : Directed and model-checked bench for regfile_rename.          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_regfile_rename;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Default configuration instance
    logic        flush, dispatch_en, commit_en;
    logic [2:0]  dispatch_dest, dispatch_tag, commit_dest, commit_tag;
    logic [15:0] commit_data;
    logic [5:0]  rd_idx;
    logic [31:0] rd_data;
    logic [1:0]  rd_busy;
    logic [5:0]  rd_tag;

    regfile_rename u_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .dispatch_en(dispatch_en), .dispatch_dest(dispatch_dest), .dispatch_tag(dispatch_tag),
        .commit_en(commit_en), .commit_dest(commit_dest), .commit_tag(commit_tag),
        .commit_data(commit_data),
        .rd_idx(rd_idx), .rd_data(rd_data), .rd_busy(rd_busy), .rd_tag(rd_tag)
    );

    // Wide configuration instance
    logic         b_flush, b_dispatch_en, b_commit_en;
    logic [3:0]   b_dispatch_dest, b_commit_dest;
    logic [2:0]   b_dispatch_tag, b_commit_tag;
    logic [31:0]  b_commit_data;
    logic [15:0]  b_rd_idx;
    logic [127:0] b_rd_data;
    logic [3:0]   b_rd_busy;
    logic [11:0]  b_rd_tag;

    regfile_rename #(.DATA_W(32), .NREGS(16), .TAG_W(3), .NUM_RD(4)) u_dut_wide (
        .clk(clk), .rst(rst), .flush(b_flush),
        .dispatch_en(b_dispatch_en), .dispatch_dest(b_dispatch_dest), .dispatch_tag(b_dispatch_tag),
        .commit_en(b_commit_en), .commit_dest(b_commit_dest), .commit_tag(b_commit_tag),
        .commit_data(b_commit_data),
        .rd_idx(b_rd_idx), .rd_data(b_rd_data), .rd_busy(b_rd_busy), .rd_tag(b_rd_tag)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        flush = 0; dispatch_en = 0; commit_en = 0;
        dispatch_dest = 0; dispatch_tag = 0;
        commit_dest = 0; commit_tag = 0; commit_data = 0;
    endtask

    task automatic chk_a(input string tag, input int p, input logic [15:0] d,
                         input logic b, input logic [2:0] t, input logic ct);
        chk({tag, "_data"}, 32'(rd_data[p*16 +: 16]), 32'(d));
        chk({tag, "_busy"}, 32'(rd_busy[p]), 32'(b));
        if (ct) chk({tag, "_tag"}, 32'(rd_tag[p*3 +: 3]), 32'(t));
    endtask

    logic [31:0] m_data [16];
    logic [2:0]  m_tag  [16];
    logic        m_busy [16];

    initial begin
        rst = 1; idle_a(); rd_idx = 0;
        b_flush = 0; b_dispatch_en = 0; b_commit_en = 0;
        b_dispatch_dest = 0; b_dispatch_tag = 0; b_commit_dest = 0;
        b_commit_tag = 0; b_commit_data = 0; b_rd_idx = 0;
        tick();
        rst = 0;

        // Reset state on every index, both ports
        for (int i = 0; i < 8; i++) begin
            rd_idx = {3'(7 - i), 3'(i)};
            #1;
            chk_a("rst_p0", 0, 16'h0, 1'b0, 3'd0, 1'b1);
            chk_a("rst_p1", 1, 16'h0, 1'b0, 3'd0, 1'b1);
        end

        // Dispatch then matching commit with bypass
        dispatch_en = 1; dispatch_dest = 3; dispatch_tag = 5;
        rd_idx = {3'd0, 3'd3};
        #1;
        chk_a("disp_invis", 0, 16'h0, 1'b0, 3'd0, 1'b0);
        tick(); idle_a(); #1;
        chk_a("r3_busy", 0, 16'h0, 1'b1, 3'd5, 1'b1);
        commit_en = 1; commit_dest = 3; commit_tag = 5; commit_data = 16'h1234;
        #1;
        chk_a("r3_bypass", 0, 16'h1234, 1'b0, 3'd0, 1'b0);
        tick(); idle_a(); #1;
        chk_a("r3_stored", 0, 16'h1234, 1'b0, 3'd0, 1'b0);

        // Re-rename: older commit must not clear busy
        dispatch_en = 1; dispatch_dest = 2; dispatch_tag = 1; tick();
        dispatch_tag = 4; tick(); idle_a();
        rd_idx = {3'd2, 3'd2};
        commit_en = 1; commit_dest = 2; commit_tag = 1; commit_data = 16'hAAAA;
        #1;
        chk_a("r2_old_byp", 1, 16'hAAAA, 1'b1, 3'd4, 1'b1);
        tick(); idle_a(); #1;
        chk_a("r2_old", 0, 16'hAAAA, 1'b1, 3'd4, 1'b1);
        commit_en = 1; commit_dest = 2; commit_tag = 4; commit_data = 16'hBBBB;
        #1;
        chk_a("r2_new_byp", 0, 16'hBBBB, 1'b0, 3'd0, 1'b0);
        tick(); idle_a(); #1;
        chk_a("r2_new", 1, 16'hBBBB, 1'b0, 3'd0, 1'b0);

        // Same-cycle commit and dispatch to one register
        dispatch_en = 1; dispatch_dest = 6; dispatch_tag = 2; tick(); idle_a();
        rd_idx = {3'd6, 3'd0};
        commit_en = 1; commit_dest = 6; commit_tag = 2; commit_data = 16'h00FF;
        dispatch_en = 1; dispatch_dest = 6; dispatch_tag = 7;
        #1;
        chk_a("r6_same", 1, 16'h00FF, 1'b0, 3'd0, 1'b0);
        tick(); idle_a(); #1;
        chk_a("r6_next", 1, 16'h00FF, 1'b1, 3'd7, 1'b1);

        // Flush with concurrent commit and dispatch
        dispatch_en = 1;
        dispatch_dest = 1; dispatch_tag = 1; tick();
        dispatch_dest = 4; dispatch_tag = 3; tick();
        dispatch_dest = 7; dispatch_tag = 6; tick();
        idle_a();
        rd_idx = {3'd7, 3'd1}; #1;
        chk_a("r1_pre", 0, 16'h0, 1'b1, 3'd1, 1'b1);
        chk_a("r7_pre", 1, 16'h0, 1'b1, 3'd6, 1'b1);
        flush = 1; commit_en = 1; commit_dest = 4; commit_tag = 3; commit_data = 16'h4444;
        dispatch_en = 1; dispatch_dest = 0; dispatch_tag = 2;
        tick(); idle_a();
        for (int i = 0; i < 8; i++) begin
            rd_idx = {3'(i), 3'(i)};
            #1;
            chk($sformatf("flush_busy_r%0d", i), 32'(rd_busy[0]), 32'd0);
        end
        rd_idx = {3'd0, 3'd4}; #1;
        chk_a("r4_flush", 0, 16'h4444, 1'b0, 3'd0, 1'b0);
        chk_a("r6_flush", 1, 16'h0, 1'b0, 3'd0, 1'b0);
        rd_idx = {3'd6, 3'd4}; #1;
        chk("r6_kept", 32'(rd_data[31:16]), 32'h00FF);

        // Commit to a non-busy register still writes data
        commit_en = 1; commit_dest = 5; commit_tag = 3; commit_data = 16'h5555;
        tick(); idle_a();
        rd_idx = {3'd5, 3'd5}; #1;
        chk_a("r5_nb", 1, 16'h5555, 1'b0, 3'd0, 1'b0);

        // Reset mid-operation dominates dispatch and commit
        dispatch_en = 1; dispatch_dest = 5; dispatch_tag = 2; tick();
        rst = 1; dispatch_dest = 3; dispatch_tag = 6;
        commit_en = 1; commit_dest = 4; commit_tag = 0; commit_data = 16'h9999;
        tick(); rst = 0; idle_a();
        rd_idx = {3'd3, 3'd5}; #1;
        chk_a("rst2_r5", 0, 16'h0, 1'b0, 3'd0, 1'b1);
        chk_a("rst2_r3", 1, 16'h0, 1'b0, 3'd0, 1'b1);
        rd_idx = {3'd6, 3'd4}; #1;
        chk_a("rst2_r4", 0, 16'h0, 1'b0, 3'd0, 1'b1);

        // Wide instance: all four ports on R15 during a commit
        b_commit_en = 1; b_commit_dest = 15; b_commit_tag = 0; b_commit_data = 32'hDEADBEEF;
        b_rd_idx = 16'hFFFF; #1;
        for (int p = 0; p < 4; p++)
            chk($sformatf("wide_byp_p%0d", p), b_rd_data[p*32 +: 32], 32'hDEADBEEF);
        tick();
        b_commit_en = 0; #1;
        for (int p = 0; p < 4; p++)
            chk($sformatf("wide_st_p%0d", p), b_rd_data[p*32 +: 32], 32'hDEADBEEF);

        for (int i = 0; i < 16; i++) begin
            m_data[i] = 0; m_tag[i] = 0; m_busy[i] = 0;
        end
        m_data[15] = 32'hDEADBEEF;

        // Random traffic against a reference model
        for (int it = 0; it < 300; it++) begin
            b_flush         = ($urandom_range(0, 15) == 0);
            b_dispatch_en   = $urandom_range(0, 1) == 1;
            b_dispatch_dest = 4'($urandom_range(0, 15));
            b_dispatch_tag  = 3'($urandom_range(0, 7));
            b_commit_en     = $urandom_range(0, 1) == 1;
            b_commit_dest   = 4'($urandom_range(0, 15));
            b_commit_tag    = ($urandom_range(0, 1) == 1) ? m_tag[b_commit_dest]
                                                          : 3'($urandom_range(0, 7));
            b_commit_data   = $urandom;
            b_rd_idx        = 16'($urandom);
            if ($urandom_range(0, 3) == 0) b_rd_idx[3:0] = b_commit_dest;
            #1;
            for (int p = 0; p < 4; p++) begin
                logic [3:0]  ix;
                logic        cm, eb;
                logic [31:0] ed;
                ix = b_rd_idx[p*4 +: 4];
                cm = b_commit_en && (b_commit_dest == ix);
                eb = m_busy[ix] && !(cm && (m_tag[ix] == b_commit_tag));
                ed = cm ? b_commit_data : m_data[ix];
                chk("rnd_data", b_rd_data[p*32 +: 32], ed);
                chk("rnd_busy", 32'(b_rd_busy[p]), 32'(eb));
                if (eb) chk("rnd_tag", 32'(b_rd_tag[p*3 +: 3]), 32'(m_tag[ix]));
            end
            if (b_commit_en) begin
                m_data[b_commit_dest] = b_commit_data;
                if (m_busy[b_commit_dest] && (m_tag[b_commit_dest] == b_commit_tag))
                    m_busy[b_commit_dest] = 0;
            end
            if (b_flush) begin
                for (int i = 0; i < 16; i++) m_busy[i] = 0;
            end else if (b_dispatch_en) begin
                m_busy[b_dispatch_dest] = 1;
                m_tag[b_dispatch_dest]  = b_dispatch_tag;
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
